// File: rtl/l1_sram_port_ctrl.sv
// L1 data-array SRAM port controller: refill/store write arbitration, read scheduling
// with same-address collision resolution, and a credit-managed read response FIFO.
module l1_sram_port_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_WMASKS   = DATA_WIDTH / 8,
  parameter int RSP_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rf_valid,
  output logic                  rf_ready,
  input  logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [NUM_WMASKS-1:0] st_wmask,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_WMASKS-1:0] mask;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t rf_req, st_req, wr_req;

  logic [SW-1:0] starve_cnt;
  logic          rd_prio;
  logic          inflight;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] wptr, rptr;
  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] mem;

  logic          st_force, st_nz, credit_ok, rd_try, rd_block;
  logic          rf_elig, st_elig, rf_gnt, st_gnt, wr_act, coll, rd_acc;
  logic          push, pop;
  logic [CW:0]   occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign rf_req = '{addr: rf_addr, mask: {NUM_WMASKS{1'b1}}, data: rf_data};
  assign st_req = '{addr: st_addr, mask: st_wmask, data: st_data};

  assign push      = inflight;
  assign pop       = rsp_valid & rsp_ready;
  assign occ       = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign credit_ok = occ < DEPTH_C;

  // A prioritised read with credit blocks same-address writes before the write
  // grant is chosen, so the other requester can still use the write port.
  assign rd_try   = rst_n & rd_valid & credit_ok;
  assign rd_block = rd_try & rd_prio;
  assign st_nz    = |st_wmask;
  assign st_force = (starve_cnt == LIMIT_C);
  assign rf_elig  = rst_n & rf_valid & ~(rd_block & (rf_addr == rd_addr));
  assign st_elig  = rst_n & st_valid & ~(rd_block & st_nz & (st_addr == rd_addr));
  assign st_gnt   = st_elig & (~rf_elig | st_force);
  assign rf_gnt   = rf_elig & ~st_gnt;
  assign wr_req   = st_gnt ? st_req : rf_req;
  // An all-zero store mask never touches the array, so it cannot collide.
  assign wr_act   = rf_gnt | (st_gnt & st_nz);
  assign coll     = rd_valid & wr_act & (wr_req.addr == rd_addr);
  assign rd_acc   = rd_try & ~coll;

  assign rf_ready    = rf_gnt;
  assign st_ready    = st_gnt;
  assign rd_ready    = rd_acc;
  assign sram_csb0   = ~wr_act;
  assign sram_wmask0 = wr_req.mask;
  assign sram_addr0  = wr_req.addr;
  assign sram_din0   = wr_req.data;
  assign sram_csb1   = ~rd_acc;
  assign sram_addr1  = rd_addr;

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_data  = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rd_prio    <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      if (!st_valid || st_gnt)
        starve_cnt <= '0;
      else if (rf_gnt && starve_cnt != LIMIT_C)
        starve_cnt <= starve_cnt + 1'b1;
      if (rd_acc)
        rd_prio <= 1'b0;
      else if (coll)
        rd_prio <= 1'b1;
      inflight <= rd_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Read credit guarantees a free entry whenever push is high.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= sram_dout1;
  end

endmodule

// File: tb/tb_l1_sram_port_ctrl.sv
// Bench for l1_sram_port_ctrl: SRAM macro model, handshake-driven memory/response
// model checked every cycle, plus directed vectors with literal expectations.
module tb_l1_sram_port_ctrl;
  localparam int AW = 8, DW = 128, NM = 16, DEPTH = 2, SL = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rf_valid, rf_ready, st_valid, st_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] rf_addr, st_addr, rd_addr, sram_addr0, sram_addr1;
  logic [DW-1:0] rf_data, st_data, rsp_data, sram_din0, sram_dout1;
  logic [NM-1:0] st_wmask, sram_wmask0;
  logic sram_csb0, sram_csb1;

  int errors = 0, checks = 0, cyc = 0;

  localparam logic [DW-1:0] D   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] RF  = 128'hCAFEF00DDEADBEEF1122334455667788;
  localparam logic [DW-1:0] SD  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [DW-1:0] S   = {16{8'hA5}};
  localparam logic [DW-1:0] S2  = {16{8'h3C}};
  localparam logic [DW-1:0] L   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [DW-1:0] L5  = 128'h00112233445566778899AABBCCDDEE5A;

  l1_sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM),
                      .RSP_DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_addr(rf_addr), .rf_data(rf_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_wmask(st_wmask),
    .st_data(st_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
    .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro: 1 write port with byte mask, 1 read port with registered output.
  logic [DW-1:0] sram [0:255];
  always @(posedge clk) begin
    if (!sram_csb0)
      for (int b = 0; b < NM; b++)
        if (sram_wmask0[b]) sram[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
    if (!sram_csb1) sram_dout1 <= sram[sram_addr1];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Model: array contents follow accepted writes; every accepted read owes one
  // response, visible two cycles after acceptance, delivered in order.
  typedef struct { logic [DW-1:0] data; int rdy; } rsp_t;
  rsp_t q[$];
  logic [DW-1:0] gold [0:255];
  logic held;
  logic [DW-1:0] held_data;

  initial begin
    logic exp_valid, wr_act, exp_pop;
    rsp_t e;
    for (int i = 0; i < 256; i++) gold[i] = '0;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk1("rst_csb0", sram_csb0, 1'b1);
        chk1("rst_csb1", sram_csb1, 1'b1);
        chk1("rst_rf_ready", rf_ready, 1'b0);
        chk1("rst_st_ready", st_ready, 1'b0);
        chk1("rst_rd_ready", rd_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        q.delete();
        held = 1'b0;
      end else begin
        chk1("rf_ready_needs_valid", rf_ready & ~rf_valid, 1'b0);
        chk1("st_ready_needs_valid", st_ready & ~st_valid, 1'b0);
        chk1("rd_ready_needs_valid", rd_ready & ~rd_valid, 1'b0);
        chk1("one_write_grant", rf_ready & st_ready, 1'b0);
        wr_act = rf_ready | (st_ready & (st_wmask != '0));
        chk1("csb0", sram_csb0, ~wr_act);
        chk1("csb1", sram_csb1, ~rd_ready);
        exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
        exp_pop   = exp_valid & rsp_ready;
        if (rd_ready) begin
          chk1("read_credit", (q.size() - int'(exp_pop)) < DEPTH, 1'b1);
          chk("rd_addr1", DW'(sram_addr1), DW'(rd_addr));
          chk1("rd_wr_same_addr", wr_act && (sram_addr0 == rd_addr), 1'b0);
        end
        if (held) begin
          chk1("rsp_hold_valid", rsp_valid, 1'b1);
          chk("rsp_hold_data", rsp_data, held_data);
        end
        chk1("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid && rsp_valid) chk("rsp_data", rsp_data, q[0].data);
        if (exp_pop) void'(q.pop_front());
        if (rd_ready) begin
          e.data = gold[rd_addr];
          e.rdy  = cyc + 2;
          q.push_back(e);
        end
        if (rf_ready) begin
          chk("rf_addr0", DW'(sram_addr0), DW'(rf_addr));
          chk("rf_wmask0", DW'(sram_wmask0), DW'(16'hFFFF));
          chk("rf_din0", sram_din0, rf_data);
          gold[rf_addr] = rf_data;
        end
        if (st_ready && st_wmask != '0) begin
          chk("st_addr0", DW'(sram_addr0), DW'(st_addr));
          chk("st_wmask0", DW'(sram_wmask0), DW'(st_wmask));
          chk("st_din0", sram_din0, st_data);
          for (int b = 0; b < NM; b++)
            if (st_wmask[b]) gold[st_addr][b*8 +: 8] = st_data[b*8 +: 8];
        end
        held      = rsp_valid & ~rsp_ready;
        held_data = rsp_data;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string name, input logic [DW-1:0] exp);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk(name, rsp_data, exp);
        got = 1'b1;
      end
      step();
    end
    if (!got) chk1({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  initial begin
    rf_valid = 1'b1; st_valid = 1'b0; rd_valid = 1'b1; rsp_ready = 1'b1;
    rf_addr = '0; st_addr = '0; rd_addr = '0; st_wmask = '0;
    rf_data = '0; st_data = '0;
    repeat (3) step();
    rf_valid = 1'b0; rd_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // refill then read back
    rf_valid = 1'b1; rf_addr = 8'h10; rf_data = D;
    @(negedge clk);
    chk1("t1_rf_ready", rf_ready, 1'b1);
    chk1("t1_csb0", sram_csb0, 1'b0);
    chk("t1_wmask0", DW'(sram_wmask0), DW'(16'hFFFF));
    step();
    rf_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'h10;
    @(negedge clk);
    chk1("t1_rd_ready", rd_ready, 1'b1);
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk1("t1_rsp_not_yet", rsp_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_data", rsp_data, D);
    step();

    // store starvation
    rf_valid = 1'b1; rf_addr = 8'h40; rf_data = RF;
    st_valid = 1'b1; st_addr = 8'h41; st_wmask = 16'hFFFF; st_data = SD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1($sformatf("t2_rf_ready_%0d", i), rf_ready, i < 4);
      chk1($sformatf("t2_st_ready_%0d", i), st_ready, i == 4);
      step();
    end
    rf_valid = 1'b0; st_valid = 1'b0;
    step();

    // same-address read/store collision
    st_valid = 1'b1; st_addr = 8'h20; st_wmask = 16'hFFFF; st_data = S;
    rd_valid = 1'b1; rd_addr = 8'h20;
    @(negedge clk);
    chk1("t3_st_wins", st_ready, 1'b1);
    chk1("t3_rd_held", rd_ready, 1'b0);
    step();
    st_data = S2;
    @(negedge clk);
    chk1("t3_rd_wins", rd_ready, 1'b1);
    chk1("t3_st_held", st_ready, 1'b0);
    chk1("t3_csb0_held", sram_csb0, 1'b1);
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk1("t3_st_later", st_ready, 1'b1);
    step();
    st_valid = 1'b0;
    wait_rsp("t3_rsp", S);

    // response backpressure and read credit
    rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 8'h10;
    @(negedge clk); chk1("t4_rd0", rd_ready, 1'b1); step();
    rd_addr = 8'h20;
    @(negedge clk); chk1("t4_rd1", rd_ready, 1'b1); step();
    rd_addr = 8'h40;
    @(negedge clk); chk1("t4_rd2_blocked", rd_ready, 1'b0); step();
    @(negedge clk);
    chk1("t4_rd2_still_blocked", rd_ready, 1'b0);
    chk1("t4_full_valid", rsp_valid, 1'b1);
    chk("t4_full_head", rsp_data, D);
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk1("t4_rd2_on_pop", rd_ready, 1'b1);
    chk("t4_rsp0", rsp_data, D);
    step();
    rd_valid = 1'b0;
    wait_rsp("t4_rsp1", S2);
    wait_rsp("t4_rsp2", RF);

    // partial byte mask and zero mask
    rf_valid = 1'b1; rf_addr = 8'h30; rf_data = L;
    @(negedge clk); chk1("t5_rf_ready", rf_ready, 1'b1); step();
    rf_valid = 1'b0;
    st_valid = 1'b1; st_addr = 8'h30; st_wmask = 16'h0001; st_data = {16{8'h5A}};
    @(negedge clk);
    chk1("t5_st_ready", st_ready, 1'b1);
    chk("t5_wmask0", DW'(sram_wmask0), DW'(16'h0001));
    step();
    st_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'h30;
    @(negedge clk); chk1("t5_rd_ready", rd_ready, 1'b1); step();
    rd_valid = 1'b0;
    wait_rsp("t5_byte0", L5);
    st_valid = 1'b1; st_addr = 8'h31; st_wmask = 16'h0000; st_data = S;
    @(negedge clk);
    chk1("t5_zero_mask_ready", st_ready, 1'b1);
    chk1("t5_zero_mask_csb0", sram_csb0, 1'b1);
    step();
    st_valid = 1'b0;

    // reset with a read in flight
    rd_valid = 1'b1; rd_addr = 8'h30;
    @(negedge clk); chk1("t6_rd_ready", rd_ready, 1'b1); step();
    rst_n = 1'b0; rf_valid = 1'b1; rf_addr = 8'h50; rf_data = S;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1("t6_rst_rsp_valid", rsp_valid, 1'b0);
      chk1("t6_rst_csb0", sram_csb0, 1'b1);
      chk1("t6_rst_csb1", sram_csb1, 1'b1);
      step();
    end
    rf_valid = 1'b0; rd_valid = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("t6_no_rsp_after_reset", rsp_valid, 1'b0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
